// File: rtl/ref_read_arbiter_if.sv
// Bus bundle between the Engine array, ref_read_arbiter and the DRAM reference reader.
// slave  : the arbiter's view.
// master : the surrounding Engines/reader's view.
interface ref_read_arbiter_if #(
    parameter int NUM_ENGINES = 4,
    parameter int REF_LENGTH  = 256,
    parameter int ADDR_W      = 25
);
    logic [NUM_ENGINES*ADDR_W-1:0] eng_ref_addr_in;
    logic [NUM_ENGINES*ADDR_W-1:0] eng_ref_length_in;
    logic [NUM_ENGINES-1:0]        eng_ref_info_valid_in;
    logic [NUM_ENGINES-1:0]        eng_ref_info_ack_out;
    logic [2*REF_LENGTH-1:0]       eng_ref_seq_block_out;
    logic [NUM_ENGINES-1:0]        eng_ref_seq_block_valid_out;
    logic [NUM_ENGINES-1:0]        eng_ref_seq_block_rdy_in;
    logic [ADDR_W-1:0]             rd_addr_out;
    logic [ADDR_W-1:0]             rd_length_out;
    logic                          rd_info_valid_out;
    logic                          rd_info_rdy_in;
    logic [2*REF_LENGTH-1:0]       rd_block_in;
    logic                          rd_block_valid_in;
    logic                          rd_block_rdy_out;

    modport slave (
        input  eng_ref_addr_in, eng_ref_length_in, eng_ref_info_valid_in,
        output eng_ref_info_ack_out, eng_ref_seq_block_out, eng_ref_seq_block_valid_out,
        input  eng_ref_seq_block_rdy_in,
        output rd_addr_out, rd_length_out, rd_info_valid_out,
        input  rd_info_rdy_in, rd_block_in, rd_block_valid_in,
        output rd_block_rdy_out
    );

    modport master (
        output eng_ref_addr_in, eng_ref_length_in, eng_ref_info_valid_in,
        input  eng_ref_info_ack_out, eng_ref_seq_block_out, eng_ref_seq_block_valid_out,
        output eng_ref_seq_block_rdy_in,
        input  rd_addr_out, rd_length_out, rd_info_valid_out,
        output rd_info_rdy_in, rd_block_in, rd_block_valid_in,
        input  rd_block_rdy_out
    );
endinterface

// File: rtl/ref_read_arbiter.sv
// ref_read_arbiter: round-robin sharing of one DRAM reference reader between
// NUM_ENGINES Engines. One request is granted at a time; its command goes to the
// reader and the returned block stream is steered to the granted Engine only.
// Optional macro REF_SHARE_EN: Engines requesting the same address/length as the
// winner join the grant and receive the same stream from a single reader command.
module ref_read_arbiter #(
    parameter int NUM_ENGINES = 4,
    parameter int REF_LENGTH  = 256,
    parameter int ADDR_W      = 25
) (
    input logic               clk,
    input logic               rst,
    ref_read_arbiter_if.slave bus
);
    localparam int unsigned N     = NUM_ENGINES;
    localparam int          IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int          BLK_W = 2 * REF_LENGTH;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STREAM, S_DONE} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_win;
    logic [N-1:0]     r_grant;
    logic [N-1:0]     r_ack;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_rd_len;
    logic [ADDR_W-1:0] r_remaining;
    logic             r_rd_info_valid;

    logic             w_hit;
    logic [IDX_W-1:0] w_win;
    logic [ADDR_W-1:0] w_win_addr;
    logic [ADDR_W-1:0] w_win_len;
    logic [N-1:0]     w_join;
    logic             w_stream;
    logic             w_members_rdy;
    logic             w_hs;

    // Round-robin search: first valid requester starting at r_rr_ptr.
    always_comb begin
        logic [IDX_W-1:0] cand;
        w_hit = 1'b0;
        w_win = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDX_W'((32'(r_rr_ptr) + k) % N);
            if (!w_hit && bus.eng_ref_info_valid_in[cand]) begin
                w_hit = 1'b1;
                w_win = cand;
            end
        end
    end

    assign w_win_addr = bus.eng_ref_addr_in[w_win*ADDR_W +: ADDR_W];
    assign w_win_len  = bus.eng_ref_length_in[w_win*ADDR_W +: ADDR_W];

`ifdef REF_SHARE_EN
    // Grant set: every requester asking for exactly the winner's address and length.
    always_comb begin
        w_join = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.eng_ref_info_valid_in[i] &&
                bus.eng_ref_addr_in[i*ADDR_W +: ADDR_W] == w_win_addr &&
                bus.eng_ref_length_in[i*ADDR_W +: ADDR_W] == w_win_len) begin
                w_join[i] = 1'b1;
            end
        end
    end
`else
    // Grant set: the winner alone.
    always_comb begin
        w_join        = '0;
        w_join[w_win] = 1'b1;
    end
`endif

    // Members not in the grant are forced ready, so a one-hot grant reduces to rdy[grant].
    assign w_stream      = (r_state == S_STREAM);
    assign w_members_rdy = &(bus.eng_ref_seq_block_rdy_in | ~r_grant);
    assign w_hs          = w_stream && bus.rd_block_valid_in && w_members_rdy;

    assign bus.rd_block_rdy_out            = w_stream && w_members_rdy;
    assign bus.eng_ref_seq_block_valid_out = (w_stream && bus.rd_block_valid_in) ? r_grant : '0;
    assign bus.eng_ref_seq_block_out       = {BLK_W{w_stream}} & bus.rd_block_in;
    assign bus.eng_ref_info_ack_out        = r_ack;
    assign bus.rd_addr_out                 = r_rd_addr;
    assign bus.rd_length_out               = r_rd_len;
    assign bus.rd_info_valid_out           = r_rd_info_valid;

    // Arbitration FSM with registered ack, reader command and transfer count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_rr_ptr        <= '0;
            r_win           <= '0;
            r_grant         <= '0;
            r_ack           <= '0;
            r_rd_addr       <= '0;
            r_rd_len        <= '0;
            r_remaining     <= '0;
            r_rd_info_valid <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_grant     <= w_join;
                        r_win       <= w_win;
                        r_ack       <= w_join;
                        r_rd_addr   <= w_win_addr;
                        r_rd_len    <= w_win_len;
                        r_remaining <= w_win_len;
                        if (w_win_len == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state         <= S_ISSUE;
                            r_rd_info_valid <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (bus.rd_info_rdy_in) begin
                        r_rd_info_valid <= 1'b0;
                        r_state         <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_hs) begin
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == ADDR_W'(1)) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_rr_ptr <= (r_win == IDX_W'(N - 1)) ? '0 : r_win + 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/ref_read_arbiter.md
Name: ref_read_arbiter

Overview:
- Shares one DRAM reference reader between NUM_ENGINES Engine instances.
- Each Engine posts a reference request (start address and block count). The arbiter grants one request at a time, round-robin, and forwards it to the reader.
- It then steers the returned block stream to the granted Engine only, and holds the grant until the requested number of blocks has transferred.
- It sits between the Engine array and the DRAM reader, on the top-level datapath.

Parameters:
- NUM_ENGINES, 4, number of requesting Engines (2..16).
- REF_LENGTH, 256, characters per reference block; block bus is 2*REF_LENGTH bits.
- ADDR_W, 25, width of address and length fields.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- eng_ref_addr_in  in  NUM_ENGINES*ADDR_W  per-Engine start address; Engine i occupies bits [i*ADDR_W +: ADDR_W].
- eng_ref_length_in  in  NUM_ENGINES*ADDR_W  per-Engine block count, same packing.
- eng_ref_info_valid_in  in  NUM_ENGINES  request pending, level.
- eng_ref_info_ack_out  out  NUM_ENGINES  one-cycle grant pulse.
- eng_ref_seq_block_out  out  2*REF_LENGTH  block data, broadcast to all Engines.
- eng_ref_seq_block_valid_out  out  NUM_ENGINES  block valid, granted Engine only.
- eng_ref_seq_block_rdy_in  in  NUM_ENGINES  Engine block ready.
- rd_addr_out  out  ADDR_W  address to reader.
- rd_length_out  out  ADDR_W  block count to reader.
- rd_info_valid_out  out  1  reader command valid.
- rd_info_rdy_in  in  1  reader command accepted.
- rd_block_in  in  2*REF_LENGTH  block data from reader.
- rd_block_valid_in  in  1  reader block valid.
- rd_block_rdy_out  out  1  block ready to reader.

Behaviour:
- Reset state:
  - State IDLE, rr_ptr=0, grant=0, remaining=0.
  - All acks, eng valids, rd_info_valid_out and rd_block_rdy_out are 0.
  - rd_addr_out, rd_length_out and eng_ref_seq_block_out are 0 (data is gated).
  - Reset mid-transfer abandons the transfer immediately. The reader shares rst, so no command or block survives.
- IDLE:
  - Choose the first i with valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_ENGINES.
  - On a hit, register: grant=i, rd_addr=addr[i], rd_length=length[i], remaining=length[i].
  - Pulse ack[i] in the next cycle.
  - Go to ISSUE, or to DONE if length[i]==0.
- ISSUE:
  - rd_info_valid_out=1, with address and length held stable until rd_info_rdy_in=1.
  - On the handshake cycle go to STREAM.
- STREAM:
  - eng_ref_seq_block_valid_out[grant] = rd_block_valid_in.
  - rd_block_rdy_out = eng_ref_seq_block_rdy_in[grant].
  - eng_ref_seq_block_out = rd_block_in.
  - All paths are combinational, zero latency.
  - remaining decrements on each valid&&rdy.
  - The handshake taken when remaining==1 moves the state to DONE.
- DONE (1 cycle):
  - rr_ptr = grant+1, wrapping NUM_ENGINES-1 to 0.
  - Return to IDLE.
  - Arbitration resumes one cycle later, so back-to-back grants have a 2-cycle gap after the last block.
- Requester rule:
  - An Engine holds valid with stable address and length until it sees its ack, then drops valid the cycle after.
  - The arbiter only samples valid in IDLE.
  - An ack is issued exactly once per granted request.
- Outside STREAM:
  - rd_block_rdy_out=0 and all eng valids are 0.
  - Reader blocks arriving early stall without loss.
  - Non-granted Engines never see valid=1.
- Length arithmetic:
  - remaining is ADDR_W bits, unsigned.
  - Length 0 means no reader command and no blocks; the ack is still sent.
- Simultaneous requests: round-robin guarantees each waiting Engine a grant within NUM_ENGINES transfers.

Optional Feature:
- Macro: REF_SHARE_EN.
- When defined, in IDLE every requesting Engine whose address and length equal the winner's joins the grant.
  - Ack pulses for all members in the same cycle.
  - In STREAM, eng valid is driven to every member.
  - rd_block_rdy_out is the AND of the members' rdy.
  - Only one reader command is issued.
  - rr_ptr = winner+1.
- When undefined, grant is strictly one-hot and the comparators are not built.

Test Plan:
- Single request, Engine 2, addr=0x100, len=3; reader rdy after 2 cycles:
  - ack[2] pulses once.
  - rd_info_valid_out held 2 cycles with addr=0x100, len=3.
  - Exactly 3 blocks reach Engine 2; other valids stay 0.
  - Returns to IDLE with rr_ptr=3.
- Engines 0, 1, 3 request together, each len=1, from reset:
  - Grant order 0, 1, 3.
  - Each ack one cycle; no overlap of block valid.
- Engine 1 rdy toggles 1,0,0,1 during len=2 stream with reader valid held:
  - remaining decrements only on handshake cycles.
  - rd_block_rdy_out mirrors Engine 1 rdy; block data stable while stalled.
- len=0 request from Engine 0:
  - ack[0] pulses.
  - rd_info_valid_out never asserts.
  - Back in IDLE after the DONE cycle; a later request from Engine 1 is granted normally.
- rst asserted mid-STREAM after 1 of 4 blocks:
  - Next cycle all outputs are 0, state IDLE, rr_ptr=0.
  - Re-request from the same Engine restarts with remaining=4.
- REF_SHARE_EN, Engines 1 and 2 request addr=0x40, len=2, Engine 3 requests addr=0x80:
  - ack[1] and ack[2] pulse together; one reader command.
  - Both see 2 blocks, and stalls by either hold the stream.
  - Engine 3 is granted next.
